hit_scheduler: RTL
==================

# hit_scheduler

Registered, handshaked successor to the combinational hit encoder. Detects rising edges on `CHAN_COUNT` hit lines and holds one pending flag per channel, so simultaneous or back-to-back hits are queued, not overwritten. Pending hits are presented one at a time as a channel index over a valid/ready interface to the downstream event logic. Hits lost to overflow are counted.

## Interface
- `CHAN_COUNT`, 8: number of hit channels, ≥2.
- `CHAN_WIDTH`, 3: channel index width, ≥ clog2(`CHAN_COUNT`).
- `LOST_WIDTH`, 8: lost-hit counter width, ≥1.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hit` in `CHAN_COUNT`: level hit inputs, synchronous to `clk`.
- `hit_out` out 1: `|pending`, combinational from registers.
- `pending` out `CHAN_COUNT`: per-channel pending flags.
- `out_valid` out 1: `out_chan` holds a pending hit.
- `out_ready` in 1: downstream accepts. Accept = `out_valid & out_ready`.
- `out_chan` out `CHAN_WIDTH`: index of presented channel.
- `lost_cnt` out `LOST_WIDTH`: saturating count of lost hits.
- `clr_lost` in 1: synchronous clear of `lost_cnt`.

## Operation
- Edge detect: `hit_q` registers `hit`, and `rise = hit & ~hit_q`. A level held high produces one event. `hit_q` resets to 0, so a line already high when reset releases counts as a rise.
- `pending[i]` sets on `rise[i]`. It clears on an accept with `out_chan == i`. If a rise and a clear hit the same channel in the same cycle, `pending[i]` stays 1 (the new hit is queued).
- Lost event: `rise[i]` while `pending[i]` is set and not being cleared that cycle.
  - `lost_cnt` adds the number of lost events in the cycle and saturates at all-ones.
  - `clr_lost` loads that cycle's lost count, normally 0.
- Eligible set = `pending` minus the channel being accepted this cycle. Rises in the current cycle are not eligible until the next cycle.
- FSM, two states:
  - IDLE: `out_valid` = 0. If the eligible set is non-zero, load `out_chan` with the arbitration winner, set `out_valid` and go to PRESENT.
  - PRESENT: `out_valid` = 1, and `out_chan` is stable until accept.
    - On accept with the eligible set non-zero: load the next winner and stay in PRESENT (back-to-back, one event per cycle).
    - On accept with the eligible set empty: go to IDLE.
    - No accept: hold.
- Arbitration is round-robin or fixed priority; see Configuration. `last_grant` updates whenever `out_chan` is loaded.

## Timing
- Reset values: `hit_q` = 0, `pending` = 0, `hit_out` = 0, `out_valid` = 0, `out_chan` = 0, `lost_cnt` = 0, state IDLE, `last_grant` = `CHAN_COUNT`-1.
- Reset is asynchronous and mid-operation aborts everything: a presented or pending hit is discarded with no handshake.
- Latency: with `hit` first sampled high at edge E0, `pending` rises after E0 and `out_valid` rises after E1 (2 edges).
- Throughput: one accept per cycle while pending hits remain.
- `out_chan` and `out_valid` are driven only by registers, with no combinational path from `hit` or `out_ready`.
- `out_valid` never drops without an accept, except on reset.

## Configuration
- `HIT_SCHED_RR_EN` defined: round-robin.
  - Search starts at `last_grant`+1, wraps modulo `CHAN_COUNT`, and takes the first eligible channel.
  - The first grant after reset searches from channel 0.
- Not defined: fixed priority, where the highest-index eligible channel wins (same convention as the earlier encoder). `last_grant` is unused and may be optimised away.

## Test plan
- Single hit, `CHAN_COUNT`=8, `out_ready`=1: pulse `hit[5]` for 1 cycle.
  - `out_valid`=1 with `out_chan`=5 two edges later, for exactly one cycle.
  - `pending` is 0 afterwards and `lost_cnt`=0.
- Simultaneous hits: `hit[1]` and `hit[6]` rise together, `out_ready`=1.
  - With RR: `out_chan` 1 then 6 on consecutive cycles.
  - Without RR: 6 then 1.
  - `hit_out` falls the cycle after the second accept.
- Stall/overflow: `out_ready`=0, pulse `hit[3]`, release it, then pulse `hit[3]` again.
  - `lost_cnt`=1 and `out_chan`=3 held stable.
  - Raise `out_ready`: one accept, then `pending`=0.
- Saturation: `LOST_WIDTH`=2, produce 5 lost events.
  - `lost_cnt`=3.
  - Pulse `clr_lost` with one simultaneous lost event: `lost_cnt`=1.
- Held level and same-cycle re-hit:
  - `hit[2]` held high for 20 cycles gives one event only.
  - A rise on channel 4 in the same cycle as its accept leaves `pending[4]`=1 and produces a second presentation of 4.
- Reset mid-operation: drop `rst_n` while `out_valid`=1 and `pending`=8'hA5.
  - All outputs go to their reset values immediately, without a clock.
  - After release, a `hit[0]` held high is detected as a new event.

Source files
------------

// File: rtl/hit_scheduler_if.sv
// -----------------------------------------------------------------------------
// hit_scheduler_if
//   Valid/ready channel carrying the index of one pending hit from the hit
//   scheduler to the downstream event logic.
//
//   Signals:
//     out_valid  - out_chan holds a pending hit (driven by the scheduler)
//     out_ready  - downstream accepts; accept = out_valid & out_ready
//     out_chan   - index of the presented channel
//
//   Modports:
//     master - the scheduler side (drives out_valid/out_chan)
//     slave  - the consumer side (drives out_ready)
// -----------------------------------------------------------------------------
interface hit_scheduler_if #(
    parameter int CHAN_WIDTH = 3
);
    logic                  out_valid;
    logic                  out_ready;
    logic [CHAN_WIDTH-1:0] out_chan;

    modport master (
        output out_valid,
        output out_chan,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_chan,
        output out_ready
    );
endinterface

// File: rtl/hit_scheduler.sv
// -----------------------------------------------------------------------------
// hit_scheduler
//   Detects rising edges on CHAN_COUNT hit lines, keeps one pending flag per
//   channel and hands pending hits out one at a time as a channel index over a
//   valid/ready channel. Hits arriving on a channel that is already pending
//   (and not being accepted in that cycle) are lost and counted in a
//   saturating counter.
//
//   Build option:
//     HIT_SCHED_RR_EN defined   - round-robin arbitration, search starts one
//                                 past the last granted channel.
//     HIT_SCHED_RR_EN undefined - fixed priority, highest eligible index wins.
//
//   Ports:
//     clk       in   clock, everything on the rising edge
//     rst_n     in   asynchronous active-low reset
//     hit       in   level hit inputs, synchronous to clk
//     hit_out   out  OR of all pending flags
//     pending   out  per-channel pending flags
//     lost_cnt  out  saturating count of lost hits
//     clr_lost  in   synchronous clear of lost_cnt
//     out_if    master modport of hit_scheduler_if (out_valid/out_ready/out_chan)
// -----------------------------------------------------------------------------
module hit_scheduler #(
    parameter int CHAN_COUNT = 8,
    parameter int CHAN_WIDTH = 3,
    parameter int LOST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHAN_COUNT-1:0] hit,
    output logic                  hit_out,
    output logic [CHAN_COUNT-1:0] pending,
    output logic [LOST_WIDTH-1:0] lost_cnt,
    input  logic                  clr_lost,
    hit_scheduler_if.master       out_if
);

    localparam int CNT_W = $clog2(CHAN_COUNT + 1);
    localparam int SUM_W = ((LOST_WIDTH > CNT_W) ? LOST_WIDTH : CNT_W) + 1;
    localparam logic [SUM_W-1:0] LOST_MAX =
        {{(SUM_W-LOST_WIDTH){1'b0}}, {LOST_WIDTH{1'b1}}};

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CHAN_COUNT-1:0] hit_q;
    logic [CHAN_COUNT-1:0] rise;
    logic [CHAN_COUNT-1:0] clr_vec;
    logic [CHAN_COUNT-1:0] eligible;
    logic [CHAN_COUNT-1:0] lost_vec;
    logic [CHAN_COUNT-1:0] pending_nxt;
    logic [CNT_W-1:0]      lost_num;
    logic [LOST_WIDTH-1:0] lost_nxt;
    logic [CHAN_WIDTH-1:0] out_chan_r;
    logic [CHAN_WIDTH-1:0] winner;
    logic                  out_valid;
    logic                  accept;
    logic                  load;

    // Number of set bits in a channel vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [CHAN_COUNT-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHAN_COUNT; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // base + inc, clamped at all-ones of the lost counter width.
    function automatic logic [LOST_WIDTH-1:0] sat_add(input logic [LOST_WIDTH-1:0] base,
                                                      input logic [CNT_W-1:0]      inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > LOST_MAX) begin
            return '1;
        end
        return sum[LOST_WIDTH-1:0];
    endfunction

    // Outputs come straight from registers (state is a single flop).
    assign out_valid       = (state == PRESENT);
    assign out_if.out_valid = out_valid;
    assign out_if.out_chan  = out_chan_r;
    assign hit_out          = |pending;

    assign accept = out_valid & out_if.out_ready;
    assign rise   = hit & ~hit_q;

    always_comb begin
        for (int i = 0; i < CHAN_COUNT; i++) begin
            clr_vec[i] = accept && (out_chan_r == CHAN_WIDTH'(i));
        end
    end

    // A rise in the same cycle as its own accept re-queues the channel
    // instead of being counted as lost. Fresh rises are not eligible yet.
    assign eligible    = pending & ~clr_vec;
    assign lost_vec    = rise & eligible;
    assign pending_nxt = eligible | rise;
    assign lost_num    = popcount(lost_vec);
    assign lost_nxt    = sat_add(clr_lost ? '0 : lost_cnt, lost_num);

`ifdef HIT_SCHED_RR_EN
    logic [CHAN_WIDTH-1:0] last_grant;

    // Pick the eligible channel at the smallest circular distance from the
    // channel after last_grant. last_grant resets to the top channel so the
    // first search after reset starts at channel 0.
    always_comb begin : rr_search
        int start;
        int dist;
        int best;
        winner = '0;
        best   = CHAN_COUNT;
        start  = (int'(last_grant) >= CHAN_COUNT - 1) ? 0 : int'(last_grant) + 1;
        for (int i = 0; i < CHAN_COUNT; i++) begin
            dist = (i >= start) ? (i - start) : (i - start + CHAN_COUNT);
            if (eligible[i] && (dist < best)) begin
                best   = dist;
                winner = CHAN_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= CHAN_WIDTH'(CHAN_COUNT - 1);
        end else if (load) begin
            last_grant <= winner;
        end
    end
`else
    // Highest eligible index wins: later iterations overwrite earlier ones.
    always_comb begin : fixed_search
        winner = '0;
        for (int i = 0; i < CHAN_COUNT; i++) begin
            if (eligible[i]) begin
                winner = CHAN_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    load      = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    if (|eligible) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hit_q      <= '0;
            pending    <= '0;
            lost_cnt   <= '0;
            out_chan_r <= '0;
        end else begin
            state    <= state_nxt;
            hit_q    <= hit;
            pending  <= pending_nxt;
            lost_cnt <= lost_nxt;
            if (load) begin
                out_chan_r <= winner;
            end
        end
    end

endmodule
